// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter sequencer for the single-cycle MIPS core. Owns the PC
// register and each cycle decides whether the PC advances by STEP, takes a
// PC-relative branch, takes an absolute jump, holds, or halts. The pc output
// drives the instruction-memory address.
//
// Parameters:
//   PC_W     - PC / address width in bits
//   STEP     - increment per sequential instruction (unsigned, < 2**PC_W)
//   RESET_PC - PC loaded on reset and on restart from HALT
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   start         in   leave IDLE/HALT and begin fetching at RESET_PC
//   stall         in   hold PC this cycle (RUN only)
//   halt_req      in   enter HALT after the current cycle
//   jump          in   load jump_target
//   jump_target   in   absolute jump address
//   branch_taken  in   take PC-relative branch
//   branch_offset in   two's-complement offset, relative to pc+STEP
//   pc            out  current PC (registered)
//   pc_plus_step  out  combinational pc+STEP mod 2**PC_W
//   running       out  1 while in RUN
//   halted        out  1 while in HALT
//   trap          out  sticky wrap-trap flag
//
// Build option:
//   PC_WRAP_TRAP_EN - when defined, a sequential/branch target that leaves
//                     the address range halts the sequencer and sets trap
//                     instead of wrapping; when undefined the PC wraps and
//                     trap stays 0.
// ============================================================================
module pc_sequencer #(
    parameter int PC_W     = 5,
    parameter int STEP     = 1,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus_step,
    output logic            running,
    output logic            halted,
    output logic            trap
);

    // Two guard bits above the PC width: bit XW-1 is the sign of the target,
    // bit XW-2 flags a target at or above 2**PC_W.
    localparam int XW = PC_W + 2;

    localparam logic [PC_W-1:0] STEP_W     = PC_W'(STEP);
    localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XW-1:0]   seq_full;
    logic [XW-1:0]   br_full;
    logic [XW-1:0]   next_full;
    logic            wrap;

    // Full-precision targets: pc and STEP are unsigned (zero-extended), the
    // branch offset is two's complement (sign-extended).
    assign seq_full  = {2'b00, pc} + {2'b00, STEP_W};
    assign br_full   = seq_full + {{2{branch_offset[PC_W-1]}}, branch_offset};
    assign next_full = branch_taken ? br_full : seq_full;

    // Out of range when negative or >= 2**PC_W; jumps never reach this path.
    assign wrap = next_full[XW-1] | next_full[XW-2];

    assign pc_plus_step = pc + STEP_W;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC_W;
            running <= 1'b0;
            halted  <= 1'b0;
            trap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= RESET_PC_W;
                        running <= 1'b1;
                    end
                end

                RUN: begin
                    // Strict priority; lower-priority requests are dropped.
                    if (halt_req) begin
                        state   <= HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (!stall) begin
                        if (jump) begin
                            pc <= jump_target;
                        end else if (TRAP_EN && wrap) begin
                            // pc keeps its pre-wrap value for inspection.
                            state   <= HALT;
                            running <= 1'b0;
                            halted  <= 1'b1;
                            trap    <= 1'b1;
                        end else begin
                            pc <= next_full[PC_W-1:0];
                        end
                    end
                end

                HALT: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= RESET_PC_W;
                        running <= 1'b1;
                        halted  <= 1'b0;
                        trap    <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    pc      <= RESET_PC_W;
                    running <= 1'b0;
                    halted  <= 1'b0;
                    trap    <= 1'b0;
                end
            endcase
        end
    end

endmodule
